// File: rtl/retire_queue_pkg.sv
// Shared types for the in-order retire queue: rename-side instruction/register types
// plus the rob_entry_t retire packet handed back to rename.
package retire_queue_pkg;

  localparam int ROBSIZE      = 16;
  localparam int ROB_IDX_BITS = $clog2(ROBSIZE);

  // Sequence ids carry one extra wrap bit so they line up with the queue pointers
  typedef logic [ROB_IDX_BITS:0] id_t;
  typedef logic [4:0]            areg_id_t;
  typedef logic [5:0]            preg_id_t;

  typedef struct packed {
    areg_id_t rd;
    logic     rd_valid;
  } si_t;

  typedef struct packed {
    id_t         id;
    logic [31:0] pc;
    si_t         si;
    preg_id_t    prd;
  } di_t;

  typedef struct packed {
    id_t         id;
    logic [31:0] pc;
    areg_id_t    ard;
    preg_id_t    prd;
    logic        needprf2arf;
  } rob_entry_t;

  function automatic rob_entry_t make_entry(input di_t di);
    rob_entry_t e;
    e.id          = di.id;
    e.pc          = di.pc;
    e.ard         = di.si.rd;
    e.prd         = di.prd;
    e.needprf2arf = di.si.rd_valid;
    return e;
  endfunction

endpackage

// File: rtl/retire_queue.sv
// In-order reorder/retire buffer between rename/dispatch and the rename free path.
// Define ROB_BYPASS_EN to let a writeback of the head entry retire in the same cycle.
module retire_queue
  import retire_queue_pkg::*;
#(
  parameter int DEPTH = ROBSIZE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  di_t                    di_i,
  input  logic                   di_i_valid,
  output logic                   di_i_ready,
  input  logic                   wb_valid_i,
  input  id_t                    wb_id_i,
  output rob_entry_t             retire_entry_o,
  output logic                   retire_entry_o_valid,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int IDXW = $clog2(DEPTH);

  typedef logic [IDXW:0] ptr_t;

  ptr_t             head_q, tail_q;
  rob_entry_t       entry_q [DEPTH];
  logic [DEPTH-1:0] valid_q, done_q;

  logic [IDXW-1:0] head_idx, tail_idx, wb_idx;
  logic            empty, full;
  logic            dispatch_fire, wb_ok, retire_fire;

  assign head_idx = head_q[IDXW-1:0];
  assign tail_idx = tail_q[IDXW-1:0];
  assign wb_idx   = wb_id_i[IDXW-1:0];

  assign empty = (head_q == tail_q);
  assign full  = (head_idx == tail_idx) && (head_q[IDXW] != tail_q[IDXW]);

  // Ready depends only on registered occupancy, so a full queue never reuses the
  // head slot in the cycle it retires.
  assign di_i_ready    = !full;
  assign dispatch_fire = di_i_valid && di_i_ready;

  // The full-id match keeps a stale writeback from marking a recycled slot done.
  assign wb_ok = wb_valid_i && valid_q[wb_idx] && (entry_q[wb_idx].id == wb_id_i);

`ifdef ROB_BYPASS_EN
  assign retire_fire = !rst && !empty && (done_q[head_idx] || (wb_ok && (wb_idx == head_idx)));
`else
  assign retire_fire = !rst && !empty && done_q[head_idx];
`endif

  assign retire_entry_o_valid = retire_fire;
  assign retire_entry_o       = retire_fire ? entry_q[head_idx] : '0;
  assign count_o              = tail_q - head_q;

  // Pointer and flag state; retire clears after writeback so a bypassed head ends clean
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      if (wb_ok) begin
        done_q[wb_idx] <= 1'b1;
      end
      if (dispatch_fire) begin
        valid_q[tail_idx] <= 1'b1;
        done_q[tail_idx]  <= 1'b0;
        tail_q            <= tail_q + ptr_t'(1);
      end
      if (retire_fire) begin
        valid_q[head_idx] <= 1'b0;
        done_q[head_idx]  <= 1'b0;
        head_q            <= head_q + ptr_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (dispatch_fire) begin
      entry_q[tail_idx] <= make_entry(di_i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (dispatch_fire) begin
        assert (di_i.id == id_t'(tail_q))
          else $error("retire_queue: dispatch id %0d does not match tail %0d", di_i.id, tail_q);
      end
      if (wb_valid_i) begin
        assert (valid_q[wb_idx])
          else $warning("retire_queue: writeback to inactive id %0d ignored", wb_id_i);
      end
    end
  end

endmodule
